// File: rtl/count_seq_monitor_pkg.sv
// count_seq_monitor_pkg: FSM state encodings and default widths shared by the monitor slice
package count_seq_monitor_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRACK = 2'd1,
    ST_ERROR = 2'd2
  } state_t;
  localparam int DEF_WIDTH  = 4;
  localparam int DEF_WRAP_W = 8;
  localparam int DEF_ERR_W  = 8;
endpackage

// File: rtl/count_seq_monitor_if.sv
// count_seq_monitor_if: counter sample inputs and monitor status outputs
interface count_seq_monitor_if #(
  parameter int WIDTH  = 4,
  parameter int WRAP_W = 8,
  parameter int ERR_W  = 8
);
  logic [WIDTH-1:0]  count;
  logic              cnt_valid;
  logic              cmp_en;
  logic [WIDTH-1:0]  cmp_value;
  logic              clr_err;
  logic              wrap_pulse;
  logic              match_pulse;
  logic              seq_err;
  logic              err_sticky;
  logic [WRAP_W-1:0] wrap_count;
  logic [ERR_W-1:0]  err_count;
  logic              in_sync;
  modport master (
    output count, cnt_valid, cmp_en, cmp_value, clr_err,
    input  wrap_pulse, match_pulse, seq_err, err_sticky, wrap_count, err_count, in_sync
  );
  modport slave (
    input  count, cnt_valid, cmp_en, cmp_value, clr_err,
    output wrap_pulse, match_pulse, seq_err, err_sticky, wrap_count, err_count, in_sync
  );
endinterface

// File: rtl/count_seq_monitor_sat_inc_counter.sv
// sat_inc_counter: saturating up-counter; a clear coincident with an increment loads 1
module sat_inc_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);
  logic [W-1:0] r_q;
  always_ff @(posedge clk) begin
    if (reset) r_q <= '0;
    else if (clr) r_q <= inc ? W'(1) : '0;
    else if (inc && !(&r_q)) r_q <= r_q + W'(1);
  end
  assign q = r_q;
endmodule

// File: rtl/count_seq_monitor.sv
// count_seq_monitor: checks a counter stream for +1 steps, reports wraps, matches and errors
module count_seq_monitor
  import count_seq_monitor_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int WRAP_W     = DEF_WRAP_W,
  parameter int ERR_W      = DEF_ERR_W,
  parameter int RESYNC_LEN = 3,
  parameter bit HOLD_OK    = 1'b0
) (
  input logic clk,
  input logic reset,
  count_seq_monitor_if.slave bus
);
  localparam int RW = $clog2(RESYNC_LEN + 1);
  state_t            r_state, w_state_nxt;
  logic [WIDTH-1:0]  r_prev;
  logic [RW-1:0]     r_resync, w_resync_nxt, w_resync_inc;
  logic              w_checked, w_legal, w_illegal, w_wrap_ev, w_match, w_resync_done;
  logic              r_wrap_pulse, r_match_pulse, r_seq_err, r_err_sticky, r_in_sync;
  logic [WRAP_W-1:0] w_wrap_count;
  logic [ERR_W-1:0]  w_err_count;
  assign w_checked     = bus.cnt_valid && (r_state == ST_TRACK || r_state == ST_ERROR);
  assign w_legal       = (bus.count == r_prev + WIDTH'(1)) || (HOLD_OK && bus.count == r_prev);
  assign w_illegal     = w_checked && !w_legal;
  assign w_wrap_ev     = w_checked && w_legal && (&r_prev) && (bus.count == '0);
  assign w_match       = bus.cnt_valid && bus.cmp_en && (bus.count == bus.cmp_value);
  assign w_resync_inc  = r_resync + RW'(1);
  assign w_resync_done = w_resync_inc == RW'(RESYNC_LEN);
  always_comb begin
    w_state_nxt  = (r_state inside {ST_IDLE, ST_TRACK, ST_ERROR}) ? r_state : ST_IDLE;
    w_resync_nxt = r_resync;
    if (bus.cnt_valid) begin
      case (r_state)
        ST_IDLE:  w_state_nxt = ST_TRACK;
        ST_TRACK: w_state_nxt = w_legal ? ST_TRACK : ST_ERROR;
        ST_ERROR: begin
          w_state_nxt  = (w_legal && w_resync_done) ? ST_TRACK : ST_ERROR;
          w_resync_nxt = (!w_legal || w_resync_done) ? '0 : w_resync_inc;
        end
        default:  w_state_nxt = ST_IDLE;
      endcase
    end
    if (bus.clr_err) begin
      w_state_nxt  = ST_IDLE;
      w_resync_nxt = '0;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_resync      <= '0;
      r_prev        <= '0;
      r_wrap_pulse  <= 1'b0;
      r_match_pulse <= 1'b0;
      r_seq_err     <= 1'b0;
      r_err_sticky  <= 1'b0;
      r_in_sync     <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_resync      <= w_resync_nxt;
      if (bus.cnt_valid) r_prev <= bus.count;
      r_wrap_pulse  <= w_wrap_ev;
      r_match_pulse <= w_match;
      r_seq_err     <= w_illegal;
      r_err_sticky  <= w_illegal || (r_err_sticky && !bus.clr_err);
      r_in_sync     <= w_state_nxt == ST_TRACK;
    end
  end
  sat_inc_counter #(.W(WRAP_W)) u_wrap_cnt (
    .clk(clk), .reset(reset), .clr(1'b0), .inc(w_wrap_ev), .q(w_wrap_count)
  );
  sat_inc_counter #(.W(ERR_W)) u_err_cnt (
    .clk(clk), .reset(reset), .clr(bus.clr_err), .inc(w_illegal), .q(w_err_count)
  );
  assign bus.wrap_pulse  = r_wrap_pulse;
  assign bus.match_pulse = r_match_pulse;
  assign bus.seq_err     = r_seq_err;
  assign bus.err_sticky  = r_err_sticky;
  assign bus.wrap_count  = w_wrap_count;
  assign bus.err_count   = w_err_count;
  assign bus.in_sync     = r_in_sync;
endmodule

// File: tb/tb_count_seq_monitor.sv
// tb_count_seq_monitor: directed checks on default, HOLD_OK=1 and WRAP_W=2 monitors
module tb_count_seq_monitor;
  logic       clk, reset;
  logic [3:0] count, cmp_value;
  logic       cnt_valid, cmp_en, clr_err;
  int         n_pass = 0, n_total = 0;
  count_seq_monitor_if #(.WIDTH(4), .WRAP_W(8), .ERR_W(8)) if0 ();
  count_seq_monitor_if #(.WIDTH(4), .WRAP_W(8), .ERR_W(8)) if1 ();
  count_seq_monitor_if #(.WIDTH(4), .WRAP_W(2), .ERR_W(8)) if2 ();
  assign {if0.count, if0.cnt_valid, if0.cmp_en, if0.cmp_value, if0.clr_err} = {count, cnt_valid, cmp_en, cmp_value, clr_err};
  assign {if1.count, if1.cnt_valid, if1.cmp_en, if1.cmp_value, if1.clr_err} = {count, cnt_valid, cmp_en, cmp_value, clr_err};
  assign {if2.count, if2.cnt_valid, if2.cmp_en, if2.cmp_value, if2.clr_err} = {count, cnt_valid, cmp_en, cmp_value, clr_err};
  count_seq_monitor #(.WRAP_W(8), .HOLD_OK(1'b0)) d0 (.clk(clk), .reset(reset), .bus(if0.slave));
  count_seq_monitor #(.WRAP_W(8), .HOLD_OK(1'b1)) d1 (.clk(clk), .reset(reset), .bus(if1.slave));
  count_seq_monitor #(.WRAP_W(2), .HOLD_OK(1'b0)) d2 (.clk(clk), .reset(reset), .bus(if2.slave));
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  task automatic step(input logic [3:0] c, input logic v);
    @(negedge clk);
    count = c;
    cnt_valid = v;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; cnt_valid = 1'b0; clr_err = 1'b0; cmp_en = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask
  task automatic test_reset();
    do_reset();
    n_total++; if ({if0.wrap_pulse, if0.match_pulse, if0.seq_err, if0.err_sticky, if0.in_sync} !== 5'b0) $display("FAIL reset_flags got=%b exp=00000", {if0.wrap_pulse, if0.match_pulse, if0.seq_err, if0.err_sticky, if0.in_sync}); else n_pass++;
    n_total++; if (if0.wrap_count !== 8'd0) $display("FAIL reset_wrap_count got=%0d exp=0", if0.wrap_count); else n_pass++;
    n_total++; if (if0.err_count !== 8'd0) $display("FAIL reset_err_count got=%0d exp=0", if0.err_count); else n_pass++;
  endtask
  task automatic test_count();
    do_reset();
    for (int i = 0; i < 18; i++) begin
      step(4'(i % 16), 1'b1);
      n_total++; if (if0.wrap_pulse !== (i == 16)) $display("FAIL count_wrap_pulse i=%0d got=%b exp=%b", i, if0.wrap_pulse, (i == 16)); else n_pass++;
      n_total++; if (if0.in_sync !== 1'b1) $display("FAIL count_in_sync i=%0d got=%b exp=1", i, if0.in_sync); else n_pass++;
      n_total++; if (if0.seq_err !== 1'b0) $display("FAIL count_seq_err i=%0d got=%b exp=0", i, if0.seq_err); else n_pass++;
    end
    n_total++; if (if0.wrap_count !== 8'd1) $display("FAIL count_wrap_count got=%0d exp=1", if0.wrap_count); else n_pass++;
    n_total++; if (if0.err_sticky !== 1'b0) $display("FAIL count_err_sticky got=%b exp=0", if0.err_sticky); else n_pass++;
  endtask
  task automatic test_resync();
    logic [3:0] seq [6] = '{4'd3, 4'd4, 4'd7, 4'd8, 4'd9, 4'd10};
    logic       exp_err [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic       exp_sync [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(seq[i], 1'b1);
      n_total++; if (if0.seq_err !== exp_err[i]) $display("FAIL resync_seq_err cnt=%0d got=%b exp=%b", seq[i], if0.seq_err, exp_err[i]); else n_pass++;
      n_total++; if (if0.in_sync !== exp_sync[i]) $display("FAIL resync_in_sync cnt=%0d got=%b exp=%b", seq[i], if0.in_sync, exp_sync[i]); else n_pass++;
    end
    n_total++; if (if0.err_count !== 8'd1) $display("FAIL resync_err_count got=%0d exp=1", if0.err_count); else n_pass++;
    n_total++; if (if0.err_sticky !== 1'b1) $display("FAIL resync_err_sticky got=%b exp=1", if0.err_sticky); else n_pass++;
  endtask
  task automatic test_match();
    int hits = 0;
    do_reset();
    cmp_en = 1'b1; cmp_value = 4'd9;
    for (int i = 0; i < 16; i++) begin
      step(4'(i), 1'b1);
      if (if0.match_pulse === 1'b1) hits++;
      n_total++; if (if0.match_pulse !== (i == 9)) $display("FAIL match_pulse i=%0d got=%b exp=%b", i, if0.match_pulse, (i == 9)); else n_pass++;
    end
    n_total++; if (hits != 1) $display("FAIL match_count got=%0d exp=1", hits); else n_pass++;
    cmp_en = 1'b0; hits = 0;
    for (int i = 0; i < 16; i++) begin
      step(4'(i), 1'b1);
      if (if0.match_pulse !== 1'b0) hits++;
    end
    n_total++; if (hits != 0) $display("FAIL match_disabled got=%0d exp=0", hits); else n_pass++;
  endtask
  task automatic test_hold();
    do_reset();
    step(4'd4, 1'b1);
    step(4'd5, 1'b1);
    step(4'd5, 1'b1);
    n_total++; if (if0.seq_err !== 1'b1) $display("FAIL hold0_seq_err got=%b exp=1", if0.seq_err); else n_pass++;
    n_total++; if (if1.seq_err !== 1'b0) $display("FAIL hold1_seq_err got=%b exp=0", if1.seq_err); else n_pass++;
    n_total++; if (if1.in_sync !== 1'b1) $display("FAIL hold1_in_sync got=%b exp=1", if1.in_sync); else n_pass++;
    cmp_en = 1'b1; cmp_value = 4'd9;
    for (int i = 0; i < 3; i++) begin
      step(4'd9, 1'b0);
      n_total++; if ({if0.seq_err, if0.match_pulse, if1.seq_err, if1.match_pulse} !== 4'b0) $display("FAIL gap_pulses i=%0d got=%b exp=0000", i, {if0.seq_err, if0.match_pulse, if1.seq_err, if1.match_pulse}); else n_pass++;
    end
    n_total++; if (if0.err_count !== 8'd1) $display("FAIL gap_err_count got=%0d exp=1", if0.err_count); else n_pass++;
    n_total++; if (if0.in_sync !== 1'b0) $display("FAIL gap_in_sync0 got=%b exp=0", if0.in_sync); else n_pass++;
    cmp_en = 1'b0;
    step(4'd6, 1'b1);
    n_total++; if (if1.seq_err !== 1'b0) $display("FAIL gap_prev_held1 got=%b exp=0", if1.seq_err); else n_pass++;
    n_total++; if (if0.seq_err !== 1'b0) $display("FAIL gap_prev_held0 got=%b exp=0", if0.seq_err); else n_pass++;
  endtask
  task automatic test_clr();
    do_reset();
    for (int i = 0; i < 17; i++) step(4'(i % 16), 1'b1);
    step(4'd1, 1'b1);
    clr_err = 1'b1;
    step(4'd5, 1'b1);
    n_total++; if (if0.seq_err !== 1'b1) $display("FAIL clr_coinc_seq_err got=%b exp=1", if0.seq_err); else n_pass++;
    n_total++; if (if0.err_sticky !== 1'b1) $display("FAIL clr_coinc_sticky got=%b exp=1", if0.err_sticky); else n_pass++;
    n_total++; if (if0.err_count !== 8'd1) $display("FAIL clr_coinc_err_count got=%0d exp=1", if0.err_count); else n_pass++;
    n_total++; if (if0.in_sync !== 1'b0) $display("FAIL clr_coinc_in_sync got=%b exp=0", if0.in_sync); else n_pass++;
    step(4'd6, 1'b0);
    n_total++; if (if0.err_sticky !== 1'b0) $display("FAIL clr_sticky got=%b exp=0", if0.err_sticky); else n_pass++;
    n_total++; if (if0.err_count !== 8'd0) $display("FAIL clr_err_count got=%0d exp=0", if0.err_count); else n_pass++;
    n_total++; if (if0.wrap_count !== 8'd1) $display("FAIL clr_wrap_count got=%0d exp=1", if0.wrap_count); else n_pass++;
    clr_err = 1'b0;
    step(4'd9, 1'b1);
    n_total++; if ({if0.seq_err, if0.in_sync} !== 2'b01) $display("FAIL clr_idle_resume got=%b exp=01", {if0.seq_err, if0.in_sync}); else n_pass++;
  endtask
  task automatic test_sat();
    do_reset();
    for (int i = 0; i < 81; i++) step(4'(i % 16), 1'b1);
    n_total++; if (if2.wrap_count !== 2'd3) $display("FAIL sat_wrap_count got=%0d exp=3", if2.wrap_count); else n_pass++;
    n_total++; if (if0.wrap_count !== 8'd5) $display("FAIL sat_wrap_count_wide got=%0d exp=5", if0.wrap_count); else n_pass++;
    step(4'd1, 1'b1);
    step(4'd2, 1'b1);
    do_reset();
    n_total++; if ({if2.wrap_pulse, if2.match_pulse, if2.seq_err, if2.err_sticky, if2.in_sync} !== 5'b0) $display("FAIL midreset_flags got=%b exp=00000", {if2.wrap_pulse, if2.match_pulse, if2.seq_err, if2.err_sticky, if2.in_sync}); else n_pass++;
    n_total++; if (if2.wrap_count !== 2'd0) $display("FAIL midreset_wrap_count got=%0d exp=0", if2.wrap_count); else n_pass++;
    step(4'd7, 1'b1);
    n_total++; if ({if2.seq_err, if2.in_sync} !== 2'b01) $display("FAIL midreset_unchecked got=%b exp=01", {if2.seq_err, if2.in_sync}); else n_pass++;
    step(4'd9, 1'b1);
    n_total++; if (if2.seq_err !== 1'b1) $display("FAIL midreset_recheck got=%b exp=1", if2.seq_err); else n_pass++;
  endtask
  initial begin
    reset = 1'b1; count = '0; cnt_valid = 1'b0; cmp_en = 1'b0; cmp_value = '0; clr_err = 1'b0;
    test_reset();
    test_count();
    test_resync();
    test_match();
    test_hold();
    test_clr();
    test_sat();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
